// File: rtl/operand_arbiter.sv
// operand_arbiter: round-robin arbiter for the shared 3:1 operand mux
// with lock override and a registered valid/ready output stage.
module operand_arbiter #(
  parameter int WIDTH = 12
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_req,
  input  logic             i_lock,
  input  logic [WIDTH-1:0] i_a_data,
  input  logic [WIDTH-1:0] i_b_data,
  input  logic [WIDTH-1:0] i_c_data,
  output logic [2:0]       o_grant,
  output logic [1:0]       o_sel,
  output logic [WIDTH-1:0] o_out_data,
  output logic             o_out_valid,
  input  logic             i_out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_last;
  logic [1:0]       r_owner;
  logic             r_locked;

  logic [1:0]       w_last;
  logic [1:0]       w_owner;
  logic [1:0]       w_i1;
  logic [1:0]       w_i2;
  logic             w_can_load;
  logic [1:0]       w_idx;
  logic             w_gnt;
  logic [WIDTH-1:0] w_mux;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Out-of-range pointers behave as their reset values
  assign w_last  = (r_last == 2'd3) ? 2'd2 : r_last;
  assign w_owner = (r_owner == 2'd3) ? 2'd0 : r_owner;
  assign w_i1    = nxt(w_last);
  assign w_i2    = nxt(w_i1);

  assign o_out_valid = (r_state == FULL);
  assign o_out_data  = r_data;
  assign w_can_load  = !o_out_valid || i_out_ready;

  // Pick the winner: locked owner first, then round-robin after last
  always_comb begin
    w_idx = 2'd3;
    if (w_can_load && (i_req != 3'b000)) begin
      if (r_locked && i_req[w_owner])
        w_idx = w_owner;
      else if (i_req[w_i1])
        w_idx = w_i1;
      else if (i_req[w_i2])
        w_idx = w_i2;
      else
        w_idx = w_last;
    end
  end

  assign w_gnt   = (w_idx != 2'd3);
  assign o_sel   = w_idx;
  assign o_grant = w_gnt ? (3'b001 << w_idx) : 3'b000;

  // Operand mux driven by the winning index only
  always_comb begin
    w_mux = '0;
    case (w_idx)
      2'd0:    w_mux = i_a_data;
      2'd1:    w_mux = i_b_data;
      2'd2:    w_mux = i_c_data;
      default: w_mux = '0;
    endcase
  end

  // Output stage FSM plus round-robin and lock bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= EMPTY;
      r_data   <= '0;
      r_last   <= 2'd2;
      r_owner  <= 2'd0;
      r_locked <= 1'b0;
    end else if (w_gnt) begin
      r_state  <= FULL;
      r_data   <= w_mux;
      r_last   <= w_idx;
      r_owner  <= w_idx;
      r_locked <= i_lock;
    end else begin
      if (r_state == FULL && i_out_ready)
        r_state <= EMPTY;
      if (!i_req[w_owner])
        r_locked <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_arbiter.sv
// tb_operand_arbiter: table-driven directed checks for operand_arbiter
// plus a hand-written lock-release-during-stall sequence.
module tb_operand_arbiter;

  localparam int W = 12;
  localparam logic [W-1:0] DA = 12'd254;
  localparam logic [W-1:0] DB = 12'd2142;
  localparam logic [W-1:0] DC = 12'd1565;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   req;
  logic         lock;
  logic [W-1:0] a_data, b_data, c_data;
  logic [2:0]   grant;
  logic [1:0]   sel;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;

  int n_run  = 0;
  int n_fail = 0;

  operand_arbiter #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_lock      (lock),
    .i_a_data    (a_data),
    .i_b_data    (b_data),
    .i_c_data    (c_data),
    .o_grant     (grant),
    .o_sel       (sel),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [2:0]   req;
    logic         lock;
    logic         rdy;
    logic [2:0]   gnt;
    logic [1:0]   sel;
    logic         v;
    logic [W-1:0] d;
  } vec_t;

  vec_t tbl[25];

  task automatic chk(input string nm, input int idx,
                     input int act, input int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d",
               nm, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input logic r,
                      input logic [2:0] q, input logic lk,
                      input logic rd, input logic [2:0] eg,
                      input logic [1:0] es, input logic ev,
                      input logic [W-1:0] ed);
    @(negedge clk);
    rst = r; req = q; lock = lk; out_ready = rd;
    #1;
    chk("grant", idx, int'(grant), int'(eg));
    chk("sel", idx, int'(sel), int'(es));
    @(posedge clk);
    #1;
    chk("out_valid", idx, int'(out_valid), int'(ev));
    chk("out_data", idx, int'(out_data), int'(ed));
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; lock = 1'b0; out_ready = 1'b1;
    a_data = DA; b_data = DB; c_data = DC;

    // rst req lock rdy | grant sel | valid data (after edge)
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0, 12'd0};
    tbl[1]  = '{1'b1, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0, 12'd0};
    tbl[2]  = '{1'b0, 3'b001, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, DA};
    tbl[3]  = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, DB};
    tbl[4]  = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[5]  = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, DA};
    tbl[6]  = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, DB};
    tbl[7]  = '{1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, DB};
    tbl[8]  = '{1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, DB};
    tbl[9]  = '{1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, DB};
    tbl[10] = '{1'b0, 3'b101, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[11] = '{1'b0, 3'b000, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0, DC};
    tbl[12] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0, DC};
    tbl[13] = '{1'b0, 3'b010, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, DB};
    tbl[14] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[15] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[16] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[17] = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[18] = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, DA};
    tbl[19] = '{1'b0, 3'b111, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, DB};
    tbl[20] = '{1'b0, 3'b101, 1'b0, 1'b1, 3'b100, 2'd2, 1'b1, DC};
    tbl[21] = '{1'b0, 3'b111, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, DA};
    tbl[22] = '{1'b0, 3'b101, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, DA};
    tbl[23] = '{1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0, 12'd0};
    tbl[24] = '{1'b0, 3'b110, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, DB};

    for (int i = 0; i < 25; i++)
      step(i, tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].rdy,
           tbl[i].gnt, tbl[i].sel, tbl[i].v, tbl[i].d);

    // Lock on A, then A drops req during a stall: lock must clear
    step(100, 1'b0, 3'b001, 1'b1, 1'b1, 3'b001, 2'd0, 1'b1, DA);
    step(101, 1'b0, 3'b010, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, DA);
    step(102, 1'b0, 3'b011, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, DB);

    // New operand values must follow the data inputs
    a_data = 12'hABC;
    step(103, 1'b0, 3'b001, 1'b0, 1'b1, 3'b001, 2'd0, 1'b1, 12'hABC);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
